// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the calculator datapath: drives the complement stage,
// then the ALU, and offers the result or an error code to the display via valid/ready.
module calc_op_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5,
   parameter int unsigned RES_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [11:0]      req_word,
   output logic             req_ready,
   output logic [11:0]      cmp_word,
   output logic             cmp_sel,
   input  logic             cmp_finish,
   output logic             alu_start,
   output logic [3:0]       alu_op,
   input  logic             alu_done,
   input  logic [RES_W-1:0] alu_result,
   output logic             res_valid,
   output logic [RES_W-1:0] res_data,
   input  logic             res_ready,
   output logic             err,
   output logic             busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMP,
      ST_ALU_GO,
      ST_ALU_WAIT,
      ST_PRESENT,
      ST_ERR
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic [11:0]        word_q, word_d;
   logic [RES_W-1:0]   data_q, data_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      data_d    = data_q;
      req_ready = 1'b0;
      cmp_sel   = 1'b0;
      alu_start = 1'b0;
      res_valid = 1'b0;
      err       = 1'b0;
      busy      = 1'b1;
      // Watchdog counter saturates rather than wrapping.
      cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               word_d = req_word;
               cnt_d  = '0;
               if (req_word[3:2] != 2'b00) begin
                  state_d = ST_ERR;
                  data_d  = '0;
               end else begin
                  state_d = ST_CMP;
               end
            end
         end
         ST_CMP: begin
            cmp_sel = 1'b1;
            cnt_d   = cnt_inc;
            // First CMP cycle (cnt=0) may still see a stale finish; finish beats timeout.
            if ((cnt_q != '0) && cmp_finish) begin
               state_d = ST_ALU_GO;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = ST_ERR;
               data_d  = '0;
            end
         end
         ST_ALU_GO: begin
            alu_start = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ALU_WAIT;
         end
         ST_ALU_WAIT: begin
            cnt_d = cnt_inc;
            if (alu_done) begin
               data_d  = alu_result;
               state_d = ST_PRESENT;
            end else if (cnt_q >= CNT_LAST) begin
               data_d  = '0;
               state_d = ST_ERR;
            end
         end
         ST_PRESENT: begin
            res_valid = 1'b1;
            if (res_ready) state_d = ST_IDLE;
         end
         ST_ERR: begin
            res_valid = 1'b1;
            err       = 1'b1;
            if (res_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cmp_word = word_q;
   assign alu_op   = word_q[3:0];
   assign res_data = data_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized and directed bench for calc_op_sequencer, checked every cycle against
// a per-transaction timeline model derived from the operation's phase rules.
module tb_calc_op_sequencer;

   localparam int TMO = 16;
   localparam int LEN = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [11:0] req_word = '0;
   logic        req_ready;
   logic [11:0] cmp_word;
   logic        cmp_sel;
   logic        cmp_finish = 1'b0;
   logic        alu_start;
   logic [3:0]  alu_op;
   logic        alu_done = 1'b0;
   logic [7:0]  alu_result = '0;
   logic        res_valid;
   logic [7:0]  res_data;
   logic        res_ready = 1'b0;
   logic        err;
   logic        busy;

   calc_op_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5), .RES_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_word(req_word), .req_ready(req_ready),
      .cmp_word(cmp_word), .cmp_sel(cmp_sel), .cmp_finish(cmp_finish),
      .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
      .alu_result(alu_result), .res_valid(res_valid), .res_data(res_data),
      .res_ready(res_ready), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Input waveforms per cycle after the accept edge.
   logic       fin_w  [LEN];
   logic       done_w [LEN];
   logic       rdy_w  [LEN];
   logic       rv_w   [LEN];
   logic [7:0] res_w  [LEN];

   // Model timeline for the current transaction.
   int         pl_cmp_last, pl_go, pl_p, pl_r;
   logic       pl_err;
   logic [7:0] pl_res;
   logic [11:0] cur_word = '0;

   logic        chk_en = 1'b0;
   logic        exp_req_ready, exp_busy, exp_cmp_sel, exp_alu_start, exp_res_valid, exp_err;
   logic [7:0]  exp_res_data;
   logic [11:0] exp_cmp_word;
   logic [3:0]  exp_alu_op;

   int         o_sel, o_start, o_start_t, o_first_rv, o_rv;
   logic [7:0] o_rd;
   logic       o_err;
   logic [3:0] o_aluop;

   // Phase timeline: CMP from cycle 0, finish honoured in cycles 1..TMO-1, else error at TMO;
   // ALU_GO one cycle, then done honoured for TMO cycles, else error; then wait for ready.
   task automatic plan(input logic legal);
      int f;
      int k;
      int ws;
      f = -1;
      k = -1;
      pl_cmp_last = -1;
      pl_go = -1;
      pl_err = 1'b1;
      pl_res = 8'h00;
      if (!legal) begin
         pl_p = 0;
      end else begin
         for (int t = 1; t < TMO; t++) if (fin_w[t] && f < 0) f = t;
         if (f < 0) begin
            pl_cmp_last = TMO - 1;
            pl_p = TMO;
         end else begin
            pl_cmp_last = f;
            pl_go = f + 1;
            ws = f + 2;
            for (int j = 0; j < TMO; j++) if (done_w[ws + j] && k < 0) k = j;
            if (k < 0) begin
               pl_p = ws + TMO;
            end else begin
               pl_p = ws + k + 1;
               pl_err = 1'b0;
               pl_res = res_w[ws + k];
            end
         end
      end
      pl_r = -1;
      for (int t = pl_p; t < LEN - 2; t++) if (rdy_w[t] && pl_r < 0) pl_r = t;
   endtask

   task automatic set_idle_exp();
      exp_req_ready = 1'b1;
      exp_busy      = 1'b0;
      exp_cmp_sel   = 1'b0;
      exp_alu_start = 1'b0;
      exp_res_valid = 1'b0;
      exp_err       = 1'b0;
      exp_res_data  = 8'h00;
      exp_cmp_word  = cur_word;
      exp_alu_op    = cur_word[3:0];
   endtask

   task automatic stray();
      cmp_finish = 1'($urandom_range(0, 1));
      alu_done   = 1'($urandom_range(0, 1));
      res_ready  = 1'($urandom_range(0, 1));
      alu_result = 8'($urandom);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
         chk("busy",      32'(busy),      32'(exp_busy));
         chk("cmp_sel",   32'(cmp_sel),   32'(exp_cmp_sel));
         chk("alu_start", 32'(alu_start), 32'(exp_alu_start));
         chk("res_valid", 32'(res_valid), 32'(exp_res_valid));
         chk("err",       32'(err),       32'(exp_err));
         chk("cmp_word",  32'(cmp_word),  32'(exp_cmp_word));
         chk("alu_op",    32'(alu_op),    32'(exp_alu_op));
         if (exp_res_valid) chk("res_data", 32'(res_data), 32'(exp_res_data));
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         req_word  = 12'($urandom);
         stray();
         set_idle_exp();
         @(negedge clk);
      end
   endtask

   task automatic run_txn(input logic [11:0] w, input logic pre_fin);
      plan(w[3:2] == 2'b00);
      if (pl_r < 0) begin
         $display("FAIL plan: no res_ready within window");
         bad++;
         total++;
         pl_r = LEN - 3;
      end
      @(posedge clk); #1;
      stray();
      req_valid  = 1'b1;
      req_word   = w;
      cmp_finish = pre_fin;
      set_idle_exp();
      @(negedge clk);
      cur_word = w;
      o_sel = 0; o_start = 0; o_start_t = -1; o_first_rv = -1; o_rv = 0;
      o_rd = 8'h00; o_err = 1'b0; o_aluop = 4'h0;
      for (int t = 0; t <= pl_r + 1; t++) begin
         @(posedge clk); #1;
         if (t <= pl_r) begin
            req_valid  = rv_w[t];
            req_word   = 12'($urandom);
            cmp_finish = fin_w[t];
            alu_done   = done_w[t];
            alu_result = res_w[t];
            res_ready  = rdy_w[t];
            exp_req_ready = 1'b0;
            exp_busy      = 1'b1;
            exp_cmp_sel   = (t <= pl_cmp_last);
            exp_alu_start = (t == pl_go);
            exp_res_valid = (t >= pl_p);
            exp_err       = (t >= pl_p) && pl_err;
            exp_res_data  = pl_res;
            exp_cmp_word  = w;
            exp_alu_op    = w[3:0];
         end else begin
            req_valid = 1'b0;
            stray();
            set_idle_exp();
         end
         @(negedge clk);
         if (t <= pl_r) begin
            if (t == 0) o_aluop = alu_op;
            if (cmp_sel) o_sel++;
            if (alu_start) begin o_start++; o_start_t = t; end
            if (res_valid) begin
               o_rv++;
               if (o_first_rv < 0) begin o_first_rv = t; o_rd = res_data; o_err = err; end
            end
         end
      end
   endtask

   task automatic fill(input logic f, input logic d, input logic r, input logic v);
      for (int t = 0; t < LEN; t++) begin
         fin_w[t] = f; done_w[t] = d; rdy_w[t] = r; rv_w[t] = v; res_w[t] = 8'($urandom);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_cmp_sel",   32'(cmp_sel),   32'd0);
      chk("rst_alu_start", 32'(alu_start), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_cmp_word",  32'(cmp_word),  32'd0);
      chk("rst_alu_op",    32'(alu_op),    32'd0);
      chk("rst_res_data",  32'(res_data),  32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [11:0] w;
      int unsigned fp, dp, rp;

      repeat (3) @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle_exp();
      chk_en = 1'b1;
      idle_cycles(3);

      // Normal flow: finish in second CMP cycle, done in third ALU_WAIT cycle.
      fill(1'b0, 1'b0, 1'b1, 1'b0);
      for (int t = 1; t < LEN; t++) fin_w[t] = 1'b1;
      done_w[1] = 1'b1;
      done_w[5] = 1'b1;
      res_w[5]  = 8'h08;
      run_txn(12'h352, 1'b0);
      chk("t1_first_rv", 32'(o_first_rv), 32'd6);
      chk("t1_start_cnt", 32'(o_start), 32'd1);
      chk("t1_res_data", 32'(o_rd), 32'h08);
      chk("t1_err", 32'(o_err), 32'd0);
      chk("t1_alu_op", 32'(o_aluop), 32'd2);
      idle_cycles(2);

      // Stale finish held high across accept.
      fill(1'b1, 1'b1, 1'b1, 1'b0);
      run_txn(12'h461, 1'b1);
      chk("t2_sel_cnt", 32'(o_sel), 32'd2);
      chk("t2_start_t", 32'(o_start_t), 32'd2);
      chk("t2_first_rv", 32'(o_first_rv), 32'd4);
      idle_cycles(2);

      // ALU timeout.
      fill(1'b1, 1'b0, 1'b1, 1'b0);
      run_txn(12'h573, 1'b0);
      chk("t3a_wait_len", 32'(o_first_rv - (o_start_t + 1)), 32'd16);
      chk("t3a_err", 32'(o_err), 32'd1);
      chk("t3a_res_data", 32'(o_rd), 32'd0);
      idle_cycles(2);

      // Complement-stage timeout, with stray done throughout.
      fill(1'b0, 1'b1, 1'b1, 1'b0);
      run_txn(12'h230, 1'b0);
      chk("t3b_first_rv", 32'(o_first_rv), 32'd16);
      chk("t3b_sel_cnt", 32'(o_sel), 32'd16);
      chk("t3b_start_cnt", 32'(o_start), 32'd0);
      chk("t3b_err", 32'(o_err), 32'd1);
      idle_cycles(2);

      // Illegal op.
      fill(1'b1, 1'b1, 1'b1, 1'b0);
      run_txn(12'h12C, 1'b1);
      chk("t4_first_rv", 32'(o_first_rv), 32'd0);
      chk("t4_sel_cnt", 32'(o_sel), 32'd0);
      chk("t4_start_cnt", 32'(o_start), 32'd0);
      chk("t4_err", 32'(o_err), 32'd1);
      idle_cycles(2);

      // Backpressure: ten cycles without ready in PRESENT, new requests offered throughout.
      fill(1'b0, 1'b0, 1'b0, 1'b1);
      for (int t = 1; t < LEN; t++) fin_w[t] = 1'b1;
      done_w[5] = 1'b1;
      res_w[5]  = 8'hA7;
      for (int t = 0; t < 6; t++) rdy_w[t] = 1'b1;
      for (int t = 16; t < LEN; t++) rdy_w[t] = 1'b1;
      run_txn(12'h9E1, 1'b0);
      chk("t5_rv_cycles", 32'(o_rv), 32'd11);
      chk("t5_res_data", 32'(o_rd), 32'hA7);
      idle_cycles(2);

      // Reset during ALU_WAIT, then a late alu_done.
      chk_en = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_word = 12'h341;
      cmp_finish = 1'b1; alu_done = 1'b0; res_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_busy_pre", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      alu_done = 1'b1; alu_result = 8'h5A; cmp_finish = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_res_valid", 32'(res_valid), 32'd0);
         chk("t6_req_ready", 32'(req_ready), 32'd1);
         chk("t6_busy", 32'(busy), 32'd0);
         chk("t6_res_data", 32'(res_data), 32'd0);
      end
      @(posedge clk); #1;
      alu_done = 1'b0;
      cur_word = '0;
      set_idle_exp();
      chk_en = 1'b1;
      idle_cycles(2);

      // Randomized transactions.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0: fp = 5;
            1: fp = 30;
            2: fp = 100;
            default: fp = 0;
         endcase
         case ($urandom_range(0, 3))
            0: dp = 10;
            1: dp = 40;
            2: dp = 100;
            default: dp = 0;
         endcase
         case ($urandom_range(0, 2))
            0: rp = 20;
            1: rp = 60;
            default: rp = 100;
         endcase
         for (int t = 0; t < LEN; t++) begin
            fin_w[t]  = ($urandom_range(0, 99) < fp);
            done_w[t] = ($urandom_range(0, 99) < dp);
            rdy_w[t]  = ($urandom_range(0, 99) < rp);
            rv_w[t]   = 1'($urandom_range(0, 1));
            res_w[t]  = 8'($urandom);
         end
         rdy_w[45] = 1'b1;
         w = 12'($urandom);
         if ($urandom_range(0, 7) != 0) w[3:2] = 2'b00;
         else if (w[3:2] == 2'b00) w[3] = 1'b1;
         run_txn(w, 1'($urandom_range(0, 1)));
         idle_cycles(int'($urandom_range(0, 3)));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
